sram_port_arbiter: RTL and testbench

- Shares one single-port SRAM macro (tech_regfile_bm style: en/wen/bm/addr/dat) between NUM_REQ requesters.
- Requesters are typically AXI4 SRAM slave front-ends or a DMA/refill engine.
- Arbitration is round-robin, with an optional burst lock bounded by LOCK_MAX beats.
- Read data returns to the granted requester one cycle after the grant; the SRAM array itself sits directly below this block.

---
 rtl/sram_port_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one single-port SRAM macro (en/wen/bm/addr/dat, 1-cycle read
//   latency) between NUM_REQ requesters. Arbitration is round-robin. A
//   requester may lock the port for a burst. The lock is force-released after
//   LOCK_MAX consecutive beats, so other requesters cannot be starved.
//   Grants are combinational: a request is consumed in the same cycle in
//   which it is granted. Read data returns one cycle after the grant on the
//   shared rdata_o bus, and rvalid_o marks the requester that owns it.
//
//   Optional feature, enabled by defining SRAM_ARB_RANGE_CHK_EN:
//     - An err_o port is added.
//     - A request whose address has non-zero bits above the SRAM range is
//       still arbitrated normally, but its SRAM access is suppressed.
//     - err_o for that requester pulses one cycle after the grant.
//     - An out-of-range read returns zero data.
//   With the macro undefined, high address bits are silently truncated.

module sram_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int SRAM_DEPTH = 512,
  parameter int LOCK_MAX   = 16
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ-1:0]              we_i,
  input  logic [NUM_REQ-1:0]              lock_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] bm_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [NUM_REQ-1:0]              rvalid_o,
  output logic [DATA_WIDTH-1:0]           rdata_o,
`ifdef SRAM_ARB_RANGE_CHK_EN
  output logic [NUM_REQ-1:0]              err_o,
`endif
  output logic                            en_o,
  output logic                            wen_o,
  output logic [DATA_WIDTH/8-1:0]         bm_o,
  output logic [$clog2(SRAM_DEPTH)-1:0]   addr_o,
  output logic [DATA_WIDTH-1:0]           dat_o,
  input  logic [DATA_WIDTH-1:0]           dat_i
);

  localparam int NR_BYTES     = DATA_WIDTH / 8;
  localparam int LOG_NR_BYTES = $clog2(NR_BYTES);
  localparam int SRAM_AW      = $clog2(SRAM_DEPTH);
  localparam int IDX_W        = $clog2(NUM_REQ);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  // Value of lock_cnt on the final beat a lock is allowed to hold.
  localparam logic [7:0]       LOCK_LAST = 8'(LOCK_MAX - 1);

  typedef enum logic {
    ST_FREE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e             state_q,    state_d;
  logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
  logic [IDX_W-1:0]   owner_q,    owner_d;
  logic [7:0]         lock_cnt_q, lock_cnt_d;
  logic [NUM_REQ-1:0] rvalid_q,   rvalid_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   cand;
  logic               found;

  // The low byte-offset bits never reach the SRAM. The high bits reach it
  // only through the optional range check. Folding the whole bus into one
  // named sink keeps the discarded bits explicit.
  logic unused_addr;
  assign unused_addr = ^addr_i;

`ifdef SRAM_ARB_RANGE_CHK_EN
  localparam int HI_LSB = LOG_NR_BYTES + SRAM_AW;

  logic [NUM_REQ-1:0] addr_hi;
  logic [NUM_REQ-1:0] err_q,    err_d;
  logic               err_rd_q, err_rd_d;

  // Flag requesters whose address has any bit set above the SRAM range.
  always_comb begin
    addr_hi = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      addr_hi[k] = |(addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] >> HI_LSB);
    end
  end
`endif

  // Arbitration and next-state logic. The grant is combinational.
  always_comb begin
    // NOTE: every variable gets a default before the case statement. A path
    // that leaves one unassigned would infer a latch.
    gnt        = '0;
    gnt_idx    = '0;
    cand       = '0;
    found      = 1'b0;
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;

    case (state_q)
      ST_FREE: begin
        // Pick the first requester at or above rr_ptr, wrapping modulo NUM_REQ.
        for (int i = 0; i < NUM_REQ; i++) begin
          cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
          if (!found && req_i[cand]) begin
            found   = 1'b1;
            gnt_idx = cand;
          end
        end
        if (found) begin
          gnt[gnt_idx] = 1'b1;
          rr_ptr_d     = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);
          if (lock_i[gnt_idx]) begin
            owner_d    = gnt_idx;
            lock_cnt_d = 8'd1;
            state_d    = ST_LOCKED;
          end
        end
      end

      ST_LOCKED: begin
        // Only the owner can be served. rr_ptr already points past the owner,
        // so after a release another pending requester is served first.
        if (req_i[owner_q]) begin
          gnt[owner_q] = 1'b1;
          if (!lock_i[owner_q] || (lock_cnt_q == LOCK_LAST)) begin
            state_d    = ST_FREE;
            lock_cnt_d = 8'd0;
          end else begin
            lock_cnt_d = lock_cnt_q + 8'd1;
          end
        end else if (!lock_i[owner_q]) begin
          state_d    = ST_FREE;
          lock_cnt_d = 8'd0;
        end
      end

      default: begin
        state_d = ST_FREE;
      end
    endcase
  end

  // Drive the SRAM from the granted port. All fields are zero when idle.
  always_comb begin
    en_o   = 1'b0;
    wen_o  = 1'b0;
    bm_o   = '0;
    addr_o = '0;
    dat_o  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        en_o   = 1'b1;
        wen_o  = we_i[k];
        bm_o   = bm_i[k*NR_BYTES +: NR_BYTES];
        addr_o = addr_i[k*ADDR_WIDTH + LOG_NR_BYTES +: SRAM_AW];
        dat_o  = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
`ifdef SRAM_ARB_RANGE_CHK_EN
        // An out-of-range beat is still granted, but it must not touch
        // the array.
        if (addr_hi[k]) begin
          en_o  = 1'b0;
          wen_o = 1'b0;
        end
`endif
      end
    end
  end

  // Read-response bookkeeping for the following cycle.
  always_comb begin
    rvalid_d = gnt & ~we_i;
`ifdef SRAM_ARB_RANGE_CHK_EN
    err_d    = gnt & addr_hi;
    err_rd_d = |(gnt & ~we_i & addr_hi);
`endif
  end

  // All state registers. A reset drops any pending read response.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_FREE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      lock_cnt_q <= 8'd0;
      rvalid_q   <= '0;
`ifdef SRAM_ARB_RANGE_CHK_EN
      err_q      <= '0;
      err_rd_q   <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments. All flops then
      // update together from the values they held before the clock edge.
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= rvalid_d;
`ifdef SRAM_ARB_RANGE_CHK_EN
      err_q      <= err_d;
      err_rd_q   <= err_rd_d;
`endif
    end
  end

  assign gnt_o    = gnt;
  assign rvalid_o = rvalid_q;

`ifdef SRAM_ARB_RANGE_CHK_EN
  assign err_o   = err_q;
  // A suppressed read returns zero instead of whatever the SRAM last held.
  assign rdata_o = err_rd_q ? '0 : dat_i;
`else
  assign rdata_o = dat_i;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
//   Directed bench for sram_port_arbiter. The bench provides:
//     - A simple SRAM macro that serves the DUT's SRAM port.
//     - A behavioural model: integer round-robin pointer, burst owner, beat
//       count and a shadow memory, checked on every falling edge.
//     - Hand-computed literal checks at key points of the scenarios.
//   The optional SRAM_ARB_RANGE_CHK_EN build is covered as well.

module tb_sram_port_arbiter;

  localparam int NUM_REQ    = 2;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 64;
  localparam int SRAM_DEPTH = 512;
  localparam int LOCK_MAX   = 16;
  localparam int NB         = DATA_WIDTH / 8;
  localparam int AW         = $clog2(SRAM_DEPTH);
  localparam int HI_LSB     = $clog2(NB) + AW;

  logic                          aclk;
  logic                          aresetn;
  logic [NUM_REQ-1:0]            req_i, we_i, lock_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i;
  logic [NUM_REQ*NB-1:0]         bm_i;
  logic [NUM_REQ-1:0]            gnt_o, rvalid_o;
  logic [DATA_WIDTH-1:0]         rdata_o;
`ifdef SRAM_ARB_RANGE_CHK_EN
  logic [NUM_REQ-1:0]            err_o;
`endif
  logic                          en_o, wen_o;
  logic [NB-1:0]                 bm_o;
  logic [AW-1:0]                 addr_o;
  logic [DATA_WIDTH-1:0]         dat_o;
  logic [DATA_WIDTH-1:0]         dat_i;

  int n_checks = 0;
  int n_errors = 0;

  sram_port_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .SRAM_DEPTH(SRAM_DEPTH),
    .LOCK_MAX  (LOCK_MAX)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .req_i   (req_i),
    .we_i    (we_i),
    .lock_i  (lock_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .bm_i    (bm_i),
    .gnt_o   (gnt_o),
    .rvalid_o(rvalid_o),
    .rdata_o (rdata_o),
`ifdef SRAM_ARB_RANGE_CHK_EN
    .err_o   (err_o),
`endif
    .en_o    (en_o),
    .wen_o   (wen_o),
    .bm_o    (bm_o),
    .addr_o  (addr_o),
    .dat_o   (dat_o),
    .dat_i   (dat_i)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SRAM macro sitting below the arbiter: byte-masked writes, 1-cycle reads.
  logic [DATA_WIDTH-1:0] sram_mem [SRAM_DEPTH];
  always @(posedge aclk) begin
    if (en_o) begin
      if (wen_o) begin
        for (int b = 0; b < NB; b++)
          if (bm_o[b]) sram_mem[addr_o][8*b +: 8] <= dat_o[8*b +: 8];
      end else begin
        dat_i <= sram_mem[addr_o];
      end
    end
  end

  // ---------------- Behavioural model ----------------
  int                    m_rr;      // next index to search from
  int                    m_owner;   // -1 when no burst is active
  int                    m_beats;   // beats granted in the current burst
  logic [DATA_WIDTH-1:0] m_mem [SRAM_DEPTH];
  logic [NUM_REQ-1:0]    exp_rvalid, exp_gnt;
  logic [DATA_WIDTH-1:0] exp_rdata;
`ifdef SRAM_ARB_RANGE_CHK_EN
  logic [NUM_REQ-1:0]    exp_err;
`endif
  int                    g, word;
  logic [ADDR_WIDTH-1:0] ga;
  logic                  g_bad;

  initial begin
    for (int i = 0; i < SRAM_DEPTH; i++) begin
      m_mem[i]    = '0;
      sram_mem[i] = '0;
    end
    dat_i = '0;
  end

  // Inputs change just after the rising edge, so the outputs are stable
  // at the falling edge.
  always @(negedge aclk) begin
    if (!aresetn) begin
      check("rst_gnt", 64'(gnt_o), 64'd0);
      check("rst_en", 64'(en_o), 64'd0);
      check("rst_wen", 64'(wen_o), 64'd0);
      check("rst_rvalid", 64'(rvalid_o), 64'd0);
`ifdef SRAM_ARB_RANGE_CHK_EN
      check("rst_err", 64'(err_o), 64'd0);
      exp_err = '0;
`endif
      m_rr       = 0;
      m_owner    = -1;
      m_beats    = 0;
      exp_rvalid = '0;
      exp_rdata  = '0;
    end else begin
      check("rvalid", 64'(rvalid_o), 64'(exp_rvalid));
      if (exp_rvalid != '0) check("rdata", rdata_o, exp_rdata);
`ifdef SRAM_ARB_RANGE_CHK_EN
      check("err", 64'(err_o), 64'(exp_err));
      exp_err = '0;
`endif
      g = -1;
      if (m_owner >= 0) begin
        if (req_i[m_owner]) g = m_owner;
      end else begin
        for (int i = 0; i < NUM_REQ; i++)
          if (g < 0 && req_i[(m_rr + i) % NUM_REQ]) g = (m_rr + i) % NUM_REQ;
      end
      exp_gnt    = '0;
      exp_rvalid = '0;
      if (g >= 0) begin
        exp_gnt[g] = 1'b1;
        ga    = addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        word  = int'((ga / NB) % SRAM_DEPTH);
        g_bad = 1'b0;
`ifdef SRAM_ARB_RANGE_CHK_EN
        g_bad = (ga >> HI_LSB) != 0;
        if (g_bad) exp_err[g] = 1'b1;
`endif
        check("gnt", 64'(gnt_o), 64'(exp_gnt));
        check("en", 64'(en_o), 64'(!g_bad));
        check("wen", 64'(wen_o), 64'(we_i[g] && !g_bad));
        check("addr", 64'(addr_o), 64'(word));
        check("bm", 64'(bm_o), 64'(bm_i[g*NB +: NB]));
        check("dat", dat_o, wdata_i[g*DATA_WIDTH +: DATA_WIDTH]);
        if (we_i[g]) begin
          if (!g_bad)
            for (int b = 0; b < NB; b++)
              if (bm_i[g*NB + b]) m_mem[word][8*b +: 8] = wdata_i[g*DATA_WIDTH + 8*b +: 8];
        end else begin
          exp_rvalid[g] = 1'b1;
          exp_rdata     = g_bad ? '0 : m_mem[word];
        end
        if (m_owner < 0) begin
          m_rr = (g + 1) % NUM_REQ;
          if (lock_i[g]) begin
            m_owner = g;
            m_beats = 1;
          end
        end else begin
          m_beats++;
          if (!lock_i[g] || m_beats == LOCK_MAX) m_owner = -1;
        end
      end else begin
        check("gnt_idle", 64'(gnt_o), 64'd0);
        check("en_idle", 64'(en_o), 64'd0);
        check("wen_idle", 64'(wen_o), 64'd0);
        check("addr_idle", 64'(addr_o), 64'd0);
        check("bm_idle", 64'(bm_o), 64'd0);
        check("dat_idle", dat_o, 64'd0);
        if (m_owner >= 0 && !lock_i[m_owner]) m_owner = -1;
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_port(input int k, input logic rq, input logic w, input logic lk,
                          input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
    req_i[k]                          = rq;
    we_i[k]                           = w;
    lock_i[k]                         = lk;
    addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] = a;
    wdata_i[k*DATA_WIDTH +: DATA_WIDTH] = d;
    bm_i[k*NB +: NB]                  = m;
  endtask

  task automatic idle();
    req_i  = '0;
    we_i   = '0;
    lock_i = '0;
  endtask

  logic [NUM_REQ-1:0] lexp;

  initial begin
    aresetn = 1'b1;
    req_i = '0; we_i = '0; lock_i = '0;
    addr_i = '0; wdata_i = '0; bm_i = '0;
    #1 aresetn = 1'b0;
    tick(); tick();
    @(negedge aclk);
    check("lit_rst_en", 64'(en_o), 64'd0);
    check("lit_rst_rvalid", 64'(rvalid_o), 64'd0);
    tick();
    aresetn = 1'b1;

    // Reset arriving right after a read grant drops the pending response.
    set_port(0, 1, 0, 0, 32'h40, 64'd0, 8'hFF);
    @(negedge aclk);
    check("lit_midrd_gnt", 64'(gnt_o), 64'h1);
    tick();
    aresetn = 1'b0;
    idle();
    @(negedge aclk);
    check("lit_midrd_rvalid", 64'(rvalid_o), 64'd0);
    check("lit_midrd_en", 64'(en_o), 64'd0);
    tick();
    aresetn = 1'b1;

    // Round robin with both ports reading continuously; rr_ptr starts at 0.
    set_port(0, 1, 0, 0, 32'h40, 64'd0, 8'hFF);
    set_port(1, 1, 0, 0, 32'h48, 64'd0, 8'hFF);
    @(negedge aclk);
    check("lit_rr_gnt0", 64'(gnt_o), 64'h1);
    tick();
    @(negedge aclk);
    check("lit_rr_gnt1", 64'(gnt_o), 64'h2);
    check("lit_rr_rv1", 64'(rvalid_o), 64'h1);
    tick();
    @(negedge aclk);
    check("lit_rr_gnt2", 64'(gnt_o), 64'h1);
    check("lit_rr_rv2", 64'(rvalid_o), 64'h2);
    tick();
    @(negedge aclk);
    check("lit_rr_gnt3", 64'(gnt_o), 64'h2);
    check("lit_rr_rv3", 64'(rvalid_o), 64'h1);
    tick();
    idle();
    @(negedge aclk);
    check("lit_rr_rv4", 64'(rvalid_o), 64'h2);

    // Port1 writes, then reads back, word address 3.
    tick();
    set_port(1, 1, 1, 0, 32'h18, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    @(negedge aclk);
    check("lit_wr_gnt", 64'(gnt_o), 64'h2);
    check("lit_wr_addr", 64'(addr_o), 64'd3);
    check("lit_wr_wen", 64'(wen_o), 64'd1);
    check("lit_wr_dat", dat_o, 64'hDEADBEEF_CAFEF00D);
    tick();
    set_port(1, 1, 0, 0, 32'h18, 64'd0, 8'h00);
    @(negedge aclk);
    check("lit_rd_wen", 64'(wen_o), 64'd0);
    tick();
    idle();
    @(negedge aclk);
    check("lit_rd_rvalid", 64'(rvalid_o), 64'h2);
    check("lit_rd_rdata", rdata_o, 64'hDEADBEEF_CAFEF00D);

    // Port0 writes the low half only, using a partial byte mask.
    tick();
    set_port(0, 1, 1, 0, 32'h18, 64'h11111111_22222222, 8'h0F);
    tick();
    set_port(0, 1, 0, 0, 32'h18, 64'd0, 8'h00);
    tick();
    idle();
    @(negedge aclk);
    check("lit_bm_rdata", rdata_o, 64'hDEADBEEF_22222222);

    // A single port1 read brings rr_ptr back to 0.
    tick();
    set_port(1, 1, 0, 0, 32'h20, 64'd0, 8'h00);
    tick();
    idle();

    // Lock burst: port0 holds the port for 4 beats, dropping lock on the 4th.
    tick();
    set_port(1, 1, 0, 0, 32'h28, 64'd0, 8'h00);
    for (int b = 0; b < 4; b++) begin
      set_port(0, 1, 1, (b < 3), 32'h100 + 32'(8*b), 64'hA0 + 64'(b), 8'hFF);
      @(negedge aclk);
      check("lit_lock_gnt", 64'(gnt_o), 64'h1);
      tick();
    end
    req_i[0] = 1'b0;
    @(negedge aclk);
    check("lit_lock_p1", 64'(gnt_o), 64'h2);
    tick();
    idle();

    // Forced release: port0 locks indefinitely while port1 waits.
    tick();
    set_port(0, 1, 1, 1, 32'h200, 64'h5A5A, 8'hFF);
    set_port(1, 1, 0, 0, 32'h208, 64'd0, 8'h00);
    for (int c = 0; c < 34; c++) begin
      @(negedge aclk);
      lexp = (c == 16 || c == 33) ? 2'b10 : 2'b01;
      check("lit_force_gnt", 64'(gnt_o), 64'(lexp));
      tick();
    end
    idle();

    // Address 0x1000 lies beyond a 512 x 64-bit SRAM.
    tick(); tick();
    set_port(0, 1, 1, 0, 32'h1000, 64'h5555_5555_5555_5555, 8'hFF);
    @(negedge aclk);
    check("lit_hi_gnt", 64'(gnt_o), 64'h1);
`ifdef SRAM_ARB_RANGE_CHK_EN
    check("lit_hi_en", 64'(en_o), 64'd0);
`else
    check("lit_hi_en", 64'(en_o), 64'd1);
    check("lit_hi_addr", 64'(addr_o), 64'd0);
`endif
    tick();
    set_port(0, 1, 0, 0, 32'h0, 64'd0, 8'h00);
    @(negedge aclk);
`ifdef SRAM_ARB_RANGE_CHK_EN
    check("lit_hi_err", 64'(err_o), 64'h1);
`endif
    tick();
    set_port(0, 1, 0, 0, 32'h1000, 64'd0, 8'h00);
    @(negedge aclk);
`ifdef SRAM_ARB_RANGE_CHK_EN
    check("lit_word0_rdata", rdata_o, 64'd0);
`else
    check("lit_word0_rdata", rdata_o, 64'h5555_5555_5555_5555);
`endif
    tick();
    idle();
    @(negedge aclk);
    check("lit_hi_rd_rvalid", 64'(rvalid_o), 64'h1);
`ifdef SRAM_ARB_RANGE_CHK_EN
    check("lit_hi_rd_rdata", rdata_o, 64'd0);
    check("lit_hi_rd_err", 64'(err_o), 64'h1);
`else
    check("lit_hi_rd_rdata", rdata_o, 64'h5555_5555_5555_5555);
`endif
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
